// File: rtl/mux_rr.sv
// mux_rr: N-channel arbitrating multiplexer with a registered output slot,
// fixed-select or round-robin grant, and valid/ready handshakes.
module mux_rr #(
   parameter  int unsigned WIDTH    = 4,
   parameter  int unsigned CHANNELS = 4,
   localparam int unsigned SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          ch,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_ch,
   output logic                      out_valid,
   input  logic                      out_ready
);

   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] gnt;
   logic             gnt_valid;
   logic [WIDTH-1:0] gnt_data;
   logic             load_en;
   logic             xfer;

   // Slot can accept a new word when empty or being drained this cycle.
   assign load_en = !out_valid || out_ready;

   // Grant selection: steered channel, or first valid at/after ptr with wrap.
   always_comb begin
      gnt       = '0;
      gnt_valid = 1'b0;
      if (mode) begin
         for (int i = 0; i < int'(CHANNELS); i++) begin
            if (!gnt_valid && in_valid[i] && (SEL_W'(i) >= ptr)) begin
               gnt       = SEL_W'(i);
               gnt_valid = 1'b1;
            end
         end
         for (int i = 0; i < int'(CHANNELS); i++) begin
            if (!gnt_valid && in_valid[i]) begin
               gnt       = SEL_W'(i);
               gnt_valid = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < int'(CHANNELS); i++) begin
            if ((ch == SEL_W'(i)) && in_valid[i]) begin
               gnt       = SEL_W'(i);
               gnt_valid = 1'b1;
            end
         end
      end
   end

   // Ready decode (forced low in reset) and granted-data select.
   always_comb begin
      in_ready = '0;
      gnt_data = '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         if (gnt == SEL_W'(i)) begin
            in_ready[i] = rst_n && load_en && gnt_valid;
            gnt_data    = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign xfer = |in_ready;

   // Output slot and round-robin pointer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         ptr       <= '0;
      end else begin
         if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_ch    <= gnt;
            if (mode) begin
               if (gnt == SEL_W'(CHANNELS - 1)) ptr <= '0;
               else                              ptr <= gnt + SEL_W'(1);
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_rr.sv
// Bench for mux_rr: a 4-channel and a 3-channel instance sharing controls,
// checked each cycle against a behavioural model plus literal expectations.
module tb_mux_rr;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mode;
   logic [1:0]  ch;
   logic [15:0] in_data;
   logic [3:0]  in_valid;
   logic        out_ready;

   logic [3:0]  rdy_a;
   logic [3:0]  dat_a;
   logic [1:0]  och_a;
   logic        ov_a;
   logic [2:0]  rdy_b;
   logic [3:0]  dat_b;
   logic [1:0]  och_b;
   logic        ov_b;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   mux_rr #(.WIDTH(4), .CHANNELS(4)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .mode(mode), .ch(ch),
      .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_a),
      .out_data(dat_a), .out_ch(och_a), .out_valid(ov_a), .out_ready(out_ready)
   );

   mux_rr #(.WIDTH(4), .CHANNELS(3)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .mode(mode), .ch(ch),
      .in_data(in_data[11:0]), .in_valid(in_valid[2:0]), .in_ready(rdy_b),
      .out_data(dat_b), .out_ch(och_b), .out_valid(ov_b), .out_ready(out_ready)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Behavioural model: one slot (valid/data/channel) and a pointer per instance.
   bit m_init = 1'b0;
   int m_ptr  [2];
   bit m_vld  [2];
   int m_data [2];
   int m_ch   [2];

   int         md_n, md_g, md_idx;
   bit         md_gv, md_load;
   logic [3:0] md_v, md_act, md_exp;
   logic [15:0] md_din;

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         md_n   = (d == 0) ? 4 : 3;
         md_v   = (d == 0) ? in_valid : {1'b0, in_valid[2:0]};
         md_din = (d == 0) ? in_data  : {4'h0, in_data[11:0]};
         md_act = (d == 0) ? rdy_a    : {1'b0, rdy_b};
         md_gv  = 1'b0;
         md_g   = 0;
         if (mode) begin
            for (int k = 0; k < md_n; k++) begin
               md_idx = (m_ptr[d] + k) % md_n;
               if (!md_gv && md_v[md_idx]) begin
                  md_gv = 1'b1;
                  md_g  = md_idx;
               end
            end
         end else if (int'(ch) < md_n && md_v[ch]) begin
            md_gv = 1'b1;
            md_g  = int'(ch);
         end
         md_load = !m_vld[d] || out_ready;
         md_exp  = (rst_n && md_load && md_gv) ? (4'b0001 << md_g) : 4'b0000;

         if (m_init) begin
            chk((d == 0) ? "model_valid_a" : "model_valid_b",
                (d == 0) ? int'(ov_a) : int'(ov_b), int'(m_vld[d]));
            chk((d == 0) ? "model_data_a" : "model_data_b",
                (d == 0) ? int'(dat_a) : int'(dat_b), m_data[d]);
            chk((d == 0) ? "model_ch_a" : "model_ch_b",
                (d == 0) ? int'(och_a) : int'(och_b), m_ch[d]);
         end
         chk((d == 0) ? "model_ready_a" : "model_ready_b", int'(md_act), int'(md_exp));

         if (!rst_n) begin
            m_vld[d]  = 1'b0;
            m_data[d] = 0;
            m_ch[d]   = 0;
            m_ptr[d]  = 0;
         end else if (md_exp != 4'b0000) begin
            m_vld[d]  = 1'b1;
            m_data[d] = int'((md_din >> (4 * md_g)) & 16'h000F);
            m_ch[d]   = md_g;
            if (mode) m_ptr[d] = (md_g + 1) % md_n;
         end else if (out_ready) begin
            m_vld[d] = 1'b0;
         end
      end
      if (!rst_n) m_init = 1'b1;
   end

   // Directed scenarios with literal expectations, then random traffic.
   int exp_nib [4] = '{3, 5, 10, 15};

   initial begin
      rst_n     = 1'b0;
      mode      = 1'b1;
      ch        = 2'd0;
      in_valid  = 4'hF;
      in_data   = 16'hFA53;
      out_ready = 1'b1;

      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst_ready_a", int'(rdy_a), 0);
         chk("rst_ready_b", int'(rdy_b), 0);
         if (i == 1) begin
            chk("rst_valid", int'(ov_a), 0);
            chk("rst_data", int'(dat_a), 0);
            chk("rst_ch", int'(och_a), 0);
         end
         tick();
      end
      rst_n = 1'b1;

      @(negedge clk);
      chk("first_grant", int'(rdy_a), 1);
      chk("first_valid", int'(ov_a), 0);
      tick();

      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("rr_ch_a", int'(och_a), k % 4);
         chk("rr_ch_b", int'(och_b), k % 3);
         chk("rr_valid", int'(ov_a), 1);
         if (k < 4) chk("rr_data", int'(dat_a), exp_nib[k]);
         tick();
         if (k == 4) in_valid = 4'b1010;
      end

      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("rr_alt_ch", int'(och_a), (k % 2 == 0) ? 3 : 1);
         tick();
         if (k == 2) begin
            mode     = 1'b0;
            ch       = 2'd0;
            in_valid = 4'hF;
         end
      end

      @(negedge clk);
      chk("fix_ch0_ready", int'(rdy_a), 1);
      chk("fix_ch0_out", int'(och_a), 0);
      tick();
      mode = 1'b1;
      @(negedge clk);
      chk("rr_resume_ready", int'(rdy_a), 4);
      tick();
      mode = 1'b0;
      ch   = 2'd2;

      @(negedge clk);
      chk("rr_resume_ch", int'(och_a), 2);
      chk("fix_ready", int'(rdy_a), 4);
      tick();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("fix_ready", int'(rdy_a), 4);
         chk("fix_data", int'(dat_a), 10);
         chk("fix_ch", int'(och_a), 2);
         tick();
      end
      in_valid = 4'b1011;
      @(negedge clk);
      chk("fix_novalid_ready", int'(rdy_a), 0);
      tick();
      @(negedge clk);
      chk("fix_novalid_ready", int'(rdy_a), 0);
      chk("fix_novalid_out", int'(ov_a), 0);
      tick();

      mode     = 1'b1;
      in_valid = 4'hF;
      tick();
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_ready", int'(rdy_a), 0);
         chk("bp_valid", int'(ov_a), 1);
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", int'(rdy_a != 4'b0000), 1);
      tick();
      @(negedge clk);
      chk("bp_no_bubble", int'(ov_a), 1);
      tick();

      mode = 1'b0;
      ch   = 2'd3;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("np2_ch3_ready_b", int'(rdy_b), 0);
         chk("np2_ch3_ready_a", int'(rdy_a), 8);
         if (k >= 1) chk("np2_ch3_valid_b", int'(ov_b), 0);
         tick();
      end

      for (int k = 0; k < 3000; k++) begin
         rst_n     = ($urandom_range(0, 63) != 0);
         mode      = 1'($urandom_range(0, 1));
         ch        = 2'($urandom_range(0, 3));
         in_valid  = 4'($urandom_range(0, 15));
         in_data   = 16'($urandom_range(0, 65535));
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      rst_n = 1'b1;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
